// File: rtl/fetch_unit_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t  - FSM state encoding (IDLE, REQ, OUT)
//   PC_STEP        - sequential PC increment
//   PC_ALIGN_MASK  - clears bits [1:0] of any PC written into the stage
//   RESET_PC       - PC loaded on reset (word aligned)
//   align_pc()     - applies PC_ALIGN_MASK
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC      = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch stage, instruction memory and
// decode. Signal names keep the fetch stage's point of view (_o driven by
// fetch, _i driven by memory/decode).
//   imem_req_o / imem_addr_o / imem_ack_i / imem_data_i : memory req/ack
//   inst_valid_o / inst_o / inst_pc_o / inst_ready_i     : decode valid/ready
//
// Handshakes:
//   memory : a request is pending while imem_req_o is high; imem_addr_o is
//            held stable until the cycle imem_ack_i is high, and that cycle
//            completes it (same-cycle ack is allowed). imem_data_i is only
//            looked at while imem_ack_i is high.
//   decode : a transfer happens on a rising edge where inst_valid_o and
//            inst_ready_i are both high. While inst_valid_o is high and no
//            transfer happens, inst_o and inst_pc_o do not change.
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_ack_i, imem_data_i,
        output inst_valid_o, inst_o, inst_pc_o,
        input  inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_ack_i, imem_data_i,
        input  inst_valid_o, inst_o, inst_pc_o,
        output inst_ready_i
    );
endinterface

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: the output register towards decode.
//   clk_i, rst_i        clock, asynchronous active-high reset
//   load_i              capture data_i/pc_i and raise valid
//   clear_i             drop valid (data/pc keep their last value)
//   data_i, pc_i        instruction word and its PC to capture
//   valid_o, inst_o,    registered contents
//   inst_pc_o
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    always_comb begin
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        // Load and clear are never requested together by the FSM; load wins.
        if (load_i) begin
            valid_d   = 1'b1;
            inst_d    = data_i;
            inst_pc_d = pc_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
        end else begin
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign valid_o   = valid_q;
    assign inst_o    = inst_q;
    assign inst_pc_o = inst_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   pc_i           selected PC from the PC multiplexer
//   redirect_i     multiplexer selects beq/jump this cycle; squash current fetch
//   next_pc_o      pc_q + 4 (combinational), feeds the multiplexer
//   bus            memory req/ack and decode valid/ready (fetch_unit_if.master)
//   state_o        current FSM state, for observation
//
// Flow: IDLE (only after reset) -> REQ (request pc_q until ack) -> OUT (hold
// the fetched word until decode takes it or a redirect drops it) -> REQ ...
// A redirect that arrives while a request is pending cannot cancel it, so the
// target is parked in tgt_q, kill_q marks the pending word as stale, and the
// ack that eventually arrives is thrown away.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  pc_i,
    input  logic         redirect_i,
    output logic [31:0]  next_pc_o,
    fetch_unit_if.master bus,
    output fetch_state_t state_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         buf_load;
    logic         buf_clear;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            tgt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state and PC logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_i) begin
                    pc_d = align_pc(pc_i);
                end
            end
            REQ: begin
                if (bus.imem_ack_i) begin
                    kill_d = 1'b0;
                    if (redirect_i) begin
                        // Redirect on the ack cycle: word is stale, go straight
                        // to the new target.
                        pc_d = align_pc(pc_i);
                    end else if (kill_q) begin
                        // Word belongs to a squashed path; resume at parked target.
                        pc_d = tgt_q;
                    end else begin
                        // Clean fetch; the multiplexer is presenting PC+4.
                        pc_d    = align_pc(pc_i);
                        state_d = OUT;
                    end
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                    tgt_d  = align_pc(pc_i);
                end
            end
            OUT: begin
                if (redirect_i) begin
                    pc_d    = align_pc(pc_i);
                    state_d = REQ;
                end else if (bus.inst_ready_i) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        bus.imem_req_o = (state_q == REQ);
        buf_load       = (state_q == REQ) && bus.imem_ack_i && !redirect_i && !kill_q;
        buf_clear      = (state_q == OUT) && (redirect_i || bus.inst_ready_i);
    end

    assign bus.imem_addr_o = pc_q;
    assign next_pc_o       = pc_q + PC_STEP;
    assign state_o         = state_q;

    fetch_buffer u_buffer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (buf_load),
        .clear_i   (buf_clear),
        .data_i    (bus.imem_data_i),
        .pc_i      (pc_q),
        .valid_o   (bus.inst_valid_o),
        .inst_o    (bus.inst_o),
        .inst_pc_o (bus.inst_pc_o)
    );

endmodule
